// File: rtl/seg_pkg.sv
// seg_pkg: definitions shared by the seven-segment display blocks.
//   seg_t      - segment bit order, bit6..bit0 = a,b,c,d,e,f,g, active-high
//   SEG_BLANK  - all segments off
//   SEG_GLYPH  - hex glyph table, indexed by the nibble value 0..F
//   clog2()    - ceiling log2, used to size counters and digit indices
package seg_pkg;

    typedef struct packed {
        logic a;
        logic b;
        logic c;
        logic d;
        logic e;
        logic f;
        logic g;
    } seg_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_GLYPH [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    // Smallest width w with 2**w >= value (0 for value <= 1).
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((32'sd1 <<< width) < value) begin
            width = width + 32'sd1;
        end
        return width;
    endfunction

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to seven-segment glyph.
//   hex  in  4  nibble value 0..F
//   seg  out 7  segments, active-high, bit6..bit0 = a..g
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_GLYPH[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed seven-segment driver, one digit selected at a time.
// Displayed data is snapshotted once per frame, so mid-frame input changes never tear.
//   I_clk       in  1           system clock
//   I_rst_n     in  1           asynchronous active-low reset
//   I_en        in  1           display enable (low forces all selects off)
//   I_show_num  in  4*DIGITS    packed nibbles, nibble k shown on digit k
//   I_dp        in  DIGITS      decimal point request per digit
//   I_lz_sup    in  1           leading-zero suppression
//   I_bright    in  BRIGHT_W    PWM brightness (all-ones = full on, 0 = off)
//   O_led       out 7           segments a..g, active-high
//   O_dp        out 1           decimal point segment, active-high
//   O_dx        out DIGITS      one-hot digit select, active-high
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int SCAN_CYCLES = 1000000,
    parameter int BRIGHT_W    = 4
)
(
    input  logic                  I_clk,
    input  logic                  I_rst_n,
    input  logic                  I_en,
    input  logic [4*DIGITS-1:0]   I_show_num,
    input  logic [DIGITS-1:0]     I_dp,
    input  logic                  I_lz_sup,
    input  logic [BRIGHT_W-1:0]   I_bright,
    output logic [6:0]            O_led,
    output logic                  O_dp,
    output logic [DIGITS-1:0]     O_dx
);

    localparam int IDX_W = clog2(DIGITS);
    localparam int CNT_W = clog2(SCAN_CYCLES);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    // Blank mask for a number: digit k (k >= 1) is blank when it and all higher nibbles are zero.
    function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] num,
                                                   input logic lz);
        logic [DIGITS-1:0] mask;
        logic              upper_zero;
        mask       = '0;
        upper_zero = lz;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (num[4*k +: 4] == 4'h0);
            mask[k]    = upper_zero;
        end
        return mask;
    endfunction

    logic                  started_r;
    logic [CNT_W-1:0]      scan_cnt_r;
    logic [IDX_W-1:0]      idx_r;
    logic [BRIGHT_W-1:0]   pwm_cnt_r;
    logic [4*DIGITS-1:0]   shadow_num_r;
    logic [DIGITS-1:0]     shadow_dp_r;
    logic [DIGITS-1:0]     blank_r;
    logic [6:0]            led_r;
    logic                  dp_r;
    logic [DIGITS-1:0]     dx_r;

    logic                  scan_last_s;
    logic                  snap_s;
    logic                  pwm_on_s;
    logic [DIGITS-1:0]     sel_s;
    logic [3:0]            cur_nib_s;
    logic                  cur_dp_s;
    logic                  cur_blank_s;
    logic [6:0]            glyph_s;

    assign scan_last_s = (scan_cnt_r == SCAN_LAST);
    // First cycle after reset, and the edge where the index wraps back to digit 0.
    assign snap_s      = !started_r || (scan_last_s && (idx_r == IDX_LAST));
    assign pwm_on_s    = (I_bright == {BRIGHT_W{1'b1}}) || (pwm_cnt_r < I_bright);

    // Select the current digit's nibble, decimal point and blank flag from the snapshot.
    always_comb begin
        sel_s       = '0;
        cur_nib_s   = 4'h0;
        cur_dp_s    = 1'b0;
        cur_blank_s = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            sel_s[k]    = (idx_r == IDX_W'(k));
            cur_nib_s   = cur_nib_s | (shadow_num_r[4*k +: 4] & {4{sel_s[k]}});
            cur_dp_s    = cur_dp_s | (shadow_dp_r[k] & sel_s[k]);
            cur_blank_s = cur_blank_s | (blank_r[k] & sel_s[k]);
        end
    end

    seg_hex_decode u_hex_decode (
        .hex (cur_nib_s),
        .seg (glyph_s)
    );

    // Scan/PWM counters, digit index and frame snapshot registers.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            started_r    <= 1'b0;
            scan_cnt_r   <= '0;
            idx_r        <= '0;
            pwm_cnt_r    <= '0;
            shadow_num_r <= '0;
            shadow_dp_r  <= '0;
            blank_r      <= '0;
        end else begin
            started_r <= 1'b1;
            pwm_cnt_r <= pwm_cnt_r + BRIGHT_W'(1);
            if (snap_s) begin
                shadow_num_r <= I_show_num;
                shadow_dp_r  <= I_dp;
                blank_r      <= lz_mask(I_show_num, I_lz_sup);
            end
            // Counters hold during the snapshot cycle so digit 0 gets a full slot.
            if (started_r) begin
                if (scan_last_s) begin
                    scan_cnt_r <= '0;
                    idx_r      <= (idx_r == IDX_LAST) ? '0 : idx_r + IDX_W'(1);
                end else begin
                    scan_cnt_r <= scan_cnt_r + CNT_W'(1);
                end
            end
        end
    end

    // Output registers: segments, DP and select all change on the same edge.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            led_r <= SEG_BLANK;
            dp_r  <= 1'b0;
            dx_r  <= '0;
        end else if (started_r) begin
            led_r <= cur_blank_s ? SEG_BLANK : glyph_s;
            dp_r  <= cur_dp_s;
            dx_r  <= (I_en && pwm_on_s) ? sel_s : '0;
        end else begin
            led_r <= SEG_BLANK;
            dp_r  <= 1'b0;
            dx_r  <= '0;
        end
    end

    assign O_led = led_r;
    assign O_dp  = dp_r;
    assign O_dx  = dx_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver (DIGITS=4, SCAN_CYCLES=8, BRIGHT_W=2). A reference
// model derives the expected pins from the number of clock edges since reset
// release, using division for digit/frame position and a per-frame snapshot.
module tb_seg_scan_driver;

    localparam int DIGITS = 4;
    localparam int SCAN   = 8;
    localparam int BW     = 2;
    localparam int FP     = DIGITS * SCAN;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] show_num;
    logic [3:0]  dp_req;
    logic        lz;
    logic [1:0]  bright;
    logic [6:0]  led;
    logic        dp_o;
    logic [3:0]  dx;

    int compared   = 0;
    int mismatched = 0;
    int n          = 0;

    logic [15:0] snap_num = 16'h0;
    logic [3:0]  snap_dp  = 4'h0;
    logic        snap_lz  = 1'b0;

    logic [6:0] glyph [16] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    seg_scan_driver #(.DIGITS(DIGITS), .SCAN_CYCLES(SCAN), .BRIGHT_W(BW)) dut (
        .I_clk      (clk),
        .I_rst_n    (rst_n),
        .I_en       (en),
        .I_show_num (show_num),
        .I_dp       (dp_req),
        .I_lz_sup   (lz),
        .I_bright   (bright),
        .O_led      (led),
        .O_dp       (dp_o),
        .O_dx       (dx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s at edge %0d: observed %h expected %h", tag, n, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_led"}, {25'd0, led}, 32'd0);
        check({tag, "_dp"},  {31'd0, dp_o}, 32'd0);
        check({tag, "_dx"},  {28'd0, dx}, 32'd0);
    endtask

    // One clock edge: predict the pins, update the snapshot model, compare.
    task automatic tick();
        logic [6:0] e_led;
        logic       e_dp;
        logic [3:0] e_dx;
        int         t;
        int         d;
        bit         blank;
        bit         on;
        @(posedge clk);
        n++;
        if (n == 1) begin
            e_led = 7'h00;
            e_dp  = 1'b0;
            e_dx  = 4'h0;
        end else begin
            t     = n - 2;
            d     = (t / SCAN) % DIGITS;
            blank = snap_lz && (d != 0) && ((snap_num >> (4 * d)) == 16'd0);
            e_led = blank ? 7'h00 : glyph[snap_num[4*d +: 4]];
            e_dp  = snap_dp[d];
            on    = en && ((bright == 2'd3) || (((n - 1) % 4) < int'(bright)));
            e_dx  = on ? 4'(1 << d) : 4'h0;
        end
        if (((n - 1) % FP) == 0) begin
            snap_num = show_num;
            snap_dp  = dp_req;
            snap_lz  = lz;
        end
        #1;
        check("led", {25'd0, led}, {25'd0, e_led});
        check("dp",  {31'd0, dp_o}, {31'd0, e_dp});
        check("dx",  {28'd0, dx}, {28'd0, e_dx});
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) tick();
    endtask

    // Advance (bounded) until the next edge that shows the given digit at the given slot offset.
    task automatic run_until(input int digit, input int offset);
        int guard;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!((n >= 2) && ((((n - 2) / SCAN) % DIGITS) == digit)
                     && (((n - 2) % SCAN) == offset)) && (guard < 2 * FP));
        check("run_until_bound", {31'd0, guard < 2 * FP}, 32'd1);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        n     = 0;
    endtask

    initial begin
        logic [31:0] r;
        int          k;

        rst_n    = 1'b0;
        en       = 1'b1;
        show_num = 16'h1234;
        dp_req   = 4'h0;
        lz       = 1'b0;
        bright   = 2'd3;
        #12;
        check_zero("reset");
        release_reset();

        // Basic scan of 1234 at full brightness.
        run(2 + 2 * FP);

        // Coherence: change mid-frame while digit 2 is shown.
        run_until(2, 3);
        show_num = 16'hABCD;
        run(FP + FP / 2);

        // Leading-zero suppression.
        show_num = 16'h0050;
        lz       = 1'b1;
        run(2 * FP);
        show_num = 16'h0000;
        run(2 * FP);

        // Decimal point and brightness levels.
        show_num = 16'h1234;
        lz       = 1'b0;
        dp_req   = 4'b0100;
        run(2 * FP);
        bright   = 2'd1;
        run(FP);
        bright   = 2'd0;
        run(FP);
        bright   = 2'd2;
        run(FP);
        bright   = 2'd3;

        // Enable low for five cycles mid-frame.
        run(5);
        en = 1'b0;
        run(5);
        en = 1'b1;
        run(FP);

        // Randomized inputs, with leading zeros made likely.
        for (int i = 0; i < 600; i++) begin
            r = $urandom;
            if (r[2:0] == 3'd0) begin
                k        = $urandom_range(0, 4);
                r        = $urandom;
                show_num = r[15:0] >> (4 * k);
            end
            if (r[5:3] == 3'd1) dp_req = 4'($urandom);
            if (r[8:6] == 3'd2) lz = r[9];
            if (r[12:10] == 3'd3) bright = 2'($urandom);
            if (r[15:13] == 3'd4) en = (r[17:16] != 2'd0);
            tick();
        end

        // Reset asserted in the middle of digit 3.
        en       = 1'b1;
        bright   = 2'd3;
        show_num = 16'h8765;
        run(FP + 2);
        run_until(3, 3);
        check("pre_reset_dx", {28'd0, dx}, 32'd8);
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(posedge clk);
        #1;
        check_zero("held_reset");
        release_reset();
        run(FP + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Parametrised multiplexed seven-segment display driver for the stopwatch and timer displays. It drives DIGITS common-select digits from one packed hex/BCD word and scans one digit at a time. Over the two-digit fixed driver it adds:
- frame-coherent input capture;
- per-digit decimal points;
- leading-zero suppression;
- PWM brightness;
- a global enable.

It sits between the timing/counter datapath and the board's segment/select pins.

## Interface
- DIGITS, 4: number of digits scanned, ≥2.
- SCAN_CYCLES, 1000000: I_clk cycles each digit is selected, ≥2^BRIGHT_W.
- BRIGHT_W, 4: brightness control width.
- I_clk  in  1  system clock.
- I_rst_n  in  1  reset, asynchronous, active-low.
- I_en  in  1  display enable; low forces all selects off.
- I_show_num  in  4*DIGITS  packed digits; nibble k ([4k+3:4k]) shown on digit k, digit 0 least significant.
- I_dp  in  DIGITS  decimal point request per digit.
- I_lz_sup  in  1  suppress leading zeros when high.
- I_bright  in  BRIGHT_W  brightness level.
- O_led  out  7  segments, active-high, bit6..bit0 = a,b,c,d,e,f,g.
- O_dp  out  1  decimal point segment, active-high.
- O_dx  out  DIGITS  digit select, one-hot active-high, bit k = digit k.

## Operation
- Scan counter runs 0..SCAN_CYCLES-1. At terminal count:
  - it wraps to 0;
  - the digit index advances k→k+1, wrapping DIGITS-1→0.
- Each digit is selected for exactly SCAN_CYCLES cycles. Frame period = DIGITS*SCAN_CYCLES.
- Snapshot:
  - I_show_num, I_dp and I_lz_sup are captured into shadow registers when the index wraps to 0, and once after reset release.
  - Input changes mid-frame never show until the next frame.
- Decoder maps 0-F to the standard hex glyph set:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70;
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47.
- Leading-zero suppression, applied to the snapshot:
  - Digit k is blank (O_led=0) if shadow I_lz_sup=1, nibble k=0, and every higher nibble is 0.
  - Digit 0 is never blanked.
  - The DP still shows on a blanked digit.
- Brightness:
  - A BRIGHT_W-bit PWM counter free-runs each cycle.
  - The current select is asserted while pwm_cnt < I_bright. I_bright = all-ones forces full-on.
  - I_bright = 0 gives no select at all. O_led and O_dp are still driven.
  - I_bright is not snapshotted; it takes effect on the next cycle.
- I_en = 0:
  - O_dx = 0;
  - scan, PWM and snapshot logic keep running, so re-enable resumes mid-frame without a glitch.

## Timing
- Reset values: O_led=0, O_dp=0, O_dx=0, index=0, scan counter=0, PWM counter=0, shadows=0.
- Cycle 1 after reset release: snapshot loads.
- From cycle 2: O_dx=…0001 (subject to I_en and I_bright), with O_led showing digit 0.
- O_led, O_dp and O_dx are registered and change on the same edge. This gives one cycle of latency from index advance to pins, and no select/segment skew.
- Reset asserted mid-scan: all outputs go to reset values immediately, independent of the clock.
- Index advance and snapshot on the same edge: digit 0 of the new frame uses the new snapshot.

## Structure
- Shared package seg_pkg holds:
  - the 16-entry glyph constant (SEG_BLANK = 7'h00);
  - the segment bit-order definition;
  - a function clog2 for the index width.
- Sub-module seg_hex_decode: 4-bit in, 7-bit out, purely combinational, reusable by other display blocks.
- Top holds the counters, shadows, LZ-suppression mask (computed from the snapshot, registered once per frame) and output registers.

## Test plan
Parameters: DIGITS=4, SCAN_CYCLES=8, BRIGHT_W=2.
- Basic scan: I_show_num=16'h1234, I_bright=3, I_en=1.
  - O_dx cycles 0001→0010→0100→1000, 8 cycles each.
  - O_led = 4'h4→33, 3→79, 2→6D, 1→30.
- Coherence: change I_show_num to 16'hABCD during digit 2 of a frame.
  - The rest of that frame shows 2,1 (6D, 30).
  - The next frame shows D,C,B,A (3D, 4E, 1F, 77).
- Leading zeros: I_show_num=16'h0050, I_lz_sup=1.
  - Digits 3 and 2 have O_led=00.
  - Digit 1 = 5B, digit 0 = 7E.
  - With 16'h0000, only digit 0 shows 7E.
- DP and brightness:
  - I_dp=4'b0100 → O_dp=1 only while digit 2 is selected.
  - I_bright=1 → each select is high 1 of every 4 cycles.
  - I_bright=0 → O_dx stays 0.
- Enable and reset:
  - I_en=0 for 5 cycles → O_dx=0 and the index continues advancing.
  - I_rst_n pulled low mid-digit-3 → all outputs 0 asynchronously.
  - After release, digit 0 reappears on cycle 2.
